// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (fetch vs. data) for the core's single memory port.
// Define MEM_ARBITER_STATS_EN to add grant and stall statistics counters.
module mem_arbiter #(
    parameter int unsigned STREAK_MAX = 4,
    parameter int unsigned XLEN       = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ack,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [3:0]      dm_be,
    output logic            dm_ack,
    output logic [XLEN-1:0] dm_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]     stat_if_grants,
    output logic [31:0]     stat_dm_grants,
    output logic [31:0]     stat_stall_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [3:0] LP_STREAK_MAX = 4'(STREAK_MAX);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_streak;
    logic [3:0]      w_streak_next;
    logic            w_grant_dm;
    logic            w_grant_if;
    logic            r_owner_dm;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [3:0]      r_mem_be;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_dm_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_streak <= 4'd0;
        end else begin
            r_state  <= w_next;
            r_streak <= w_streak_next;
        end
    end

    // Data wins unless fetch has already waited out STREAK_MAX data grants.
    always_comb begin
        w_next        = r_state;
        w_streak_next = r_streak;
        w_grant_dm    = 1'b0;
        w_grant_if    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dm_req && !(if_req && (r_streak == LP_STREAK_MAX))) begin
                    w_grant_dm = 1'b1;
                    w_next     = S_ACCESS;
                    if (!if_req) begin
                        w_streak_next = 4'd0;
                    end else if (r_streak != LP_STREAK_MAX) begin
                        w_streak_next = r_streak + 4'd1;
                    end
                end else if (if_req) begin
                    w_grant_if    = 1'b1;
                    w_next        = S_ACCESS;
                    w_streak_next = 4'd0;
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner_dm  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= 4'h0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            if (w_grant_dm) begin
                r_owner_dm  <= 1'b1;
                r_mem_we    <= dm_we;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
                r_mem_be    <= dm_be;
            end else if (w_grant_if) begin
                r_owner_dm  <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
                r_mem_be    <= 4'hF;
            end
            if ((r_state == S_ACCESS) && mem_ready) begin
                if (r_owner_dm) begin
                    r_dm_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    // Handshake outputs decode straight from state so reset drops them at once.
    assign mem_req   = (r_state == S_ACCESS);
    assign if_ack    = (r_state == S_RESP) && !r_owner_dm;
    assign dm_ack    = (r_state == S_RESP) && r_owner_dm;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] r_stat_if;
    logic [31:0] r_stat_dm;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_if    <= 32'd0;
            r_stat_dm    <= 32'd0;
            r_stat_stall <= 32'd0;
        end else begin
            if (w_grant_if) begin
                r_stat_if <= r_stat_if + 32'd1;
            end
            if (w_grant_dm) begin
                r_stat_dm <= r_stat_dm + 32'd1;
            end
            if ((r_state == S_ACCESS) && !mem_ready) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_if_grants    = r_stat_if;
    assign stat_dm_grants    = r_stat_dm;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port of the RISC-V core between two requesters: instruction fetch (if_*) and the load/store data stage (dm_*).
- Sits between the pipeline stages and the memory model inside top.
- Grants one access at a time and latches the winner's request fields.
- Drives a ready-handshaked memory bus and returns the read data with a one-cycle ack pulse.
- Data accesses have priority; a streak limit guarantees fetch forward progress.

Parameters:
- STREAK_MAX, 4, max consecutive data grants while if_req is pending before fetch is forced; legal range 1..15
- XLEN, 32, address/data width

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request, held with if_addr until if_ack
- if_addr  input  XLEN  fetch address
- if_ack  output  1  one-cycle pulse, fetch done
- if_rdata  output  XLEN  fetch data, valid when if_ack=1
- dm_req  input  1  data request, held with fields until dm_ack
- dm_we  input  1  1=store, 0=load
- dm_addr  input  XLEN  data address
- dm_wdata  input  XLEN  store data
- dm_be  input  4  byte enables
- dm_ack  output  1  one-cycle pulse, data access done
- dm_rdata  output  XLEN  load data, valid when dm_ack=1
- mem_req  output  1  memory request
- mem_we  output  1  memory write enable
- mem_addr  output  XLEN  memory address
- mem_wdata  output  XLEN  memory write data
- mem_be  output  4  memory byte enables
- mem_ready  input  1  memory completes the current request in this cycle
- mem_rdata  input  XLEN  memory read data, valid with mem_ready

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, streak=0.
  - All outputs 0, including mem_req, which drops immediately.
  - Any in-flight access is abandoned and no ack is issued for it.
- State IDLE:
  - Samples if_req/dm_req.
  - Winner's fields are latched into mem_* registers; owner is recorded; go to ACCESS.
  - No request: stay in IDLE.
- Arbitration, evaluated in IDLE only:
  - Only one request: grant it.
  - Both requesting: grant dm unless streak==STREAK_MAX, in which case grant if.
- Streak counter:
  - dm grant with if_req=1: streak+1, saturating at STREAK_MAX.
  - dm grant with if_req=0, or any if grant: streak=0.
  - Width: 4 bits.
- State ACCESS:
  - mem_req=1; mem_we/addr/wdata/be are constant from the latch.
  - mem_ready=1: capture mem_rdata into the owner's rdata register, go to RESP.
  - mem_ready=0: stay in ACCESS, with no timeout.
  - Fetch grants always drive mem_we=0 and mem_be=4'hF.
- State RESP:
  - mem_req=0; owner's ack=1 for exactly this cycle; go to IDLE.
  - Requests are not sampled in RESP.
- Requester rules:
  - Fields must stay stable until ack.
  - After ack the requester may keep req high with new fields; the next IDLE cycle treats this as a new request.
- Latency and throughput:
  - Minimum latency is req in cycle 0, mem_req in cycle 1, ack in cycle 2 (with mem_ready in cycle 1).
  - Peak throughput is one access per 3 cycles.
- Store acks: rdata contents are don't-care; the bench must not check them.
- Read data: if_rdata and dm_rdata hold their last captured value between acks.
- Ack outputs: never both high in one cycle.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- When defined:
  - Adds output ports stat_if_grants [31:0], stat_dm_grants [31:0] and stat_stall_cycles [31:0].
  - stat_stall_cycles counts ACCESS cycles with mem_ready=0.
  - All three counters wrap and are cleared by reset_n.
- When undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ready=1 in every cycle, mem_rdata=0x00002013 -> mem_req/mem_addr=0x100 in cycle 1, if_ack=1 with if_rdata=0x00002013 in cycle 2.
- Store with wait: dm_req=1, dm_we=1, addr=0x2000, wdata=0xDEADBEEF, be=4'b0011, mem_ready=1 only in 3rd ACCESS cycle -> mem_* held stable for 3 cycles, dm_ack in following cycle, if_ack=0 throughout.
- Contention: if_req and dm_req both held high continuously, STREAK_MAX=4, dm re-requesting after each ack -> grant order dm,dm,dm,dm,if,dm,dm,dm,dm,if...
- Priority without starvation: dm_req=1 alone for 6 accesses, then if_req rises -> streak is 0 on entry, so next 4 grants dm then if.
- Reset mid-access: assert reset_n=0 during ACCESS -> mem_req=0 asynchronously; after release no ack for the old request and streak=0.
- Stats (MEM_ARBITER_STATS_EN): run the contention scenario for 10 accesses with 2 wait cycles each -> stat_dm_grants=8, stat_if_grants=2, stat_stall_cycles=20.
